// File: rtl/dm_store_pkg.sv
// Shared MIPS datapath definitions used by the data-memory store path.
// Contents: store-width encodings (SOp field) and byte-lane geometry.
package mips_defs;

  // Store width encodings carried on SOp.
  localparam logic [1:0] SOP_SW  = 2'b00;
  localparam logic [1:0] SOP_SH  = 2'b01;
  localparam logic [1:0] SOP_SB  = 2'b10;
  localparam logic [1:0] SOP_RSV = 2'b11;

  // Byte-lane geometry of a 32-bit word.
  localparam int unsigned LANE_W     = 8;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/store_lane_pack.sv
// Store-side narrowing: turns (width, byte offset, register value) into per-lane
// byte enables, lane-replicated write data and an alignment/reserved error flag.
// Purely combinational.
// Ports:
//   sop       - store width (SOP_SW / SOP_SH / SOP_SB / SOP_RSV)
//   addr_lo   - byte offset within the word (addr[1:0])
//   wdata     - store data (GPR[rt])
//   be        - byte enables, 0000 whenever align_err is set
//   lane_data - wdata replicated so every candidate lane carries the narrowed value
//   align_err - misaligned sw/sh or reserved encoding
module store_lane_pack
  import mips_defs::*;
(
  input  logic [1:0]                   sop,
  input  logic [1:0]                   addr_lo,
  input  logic [WORD_BYTES*LANE_W-1:0] wdata,
  output logic [WORD_BYTES-1:0]        be,
  output logic [WORD_BYTES*LANE_W-1:0] lane_data,
  output logic                         align_err
);

  always_comb begin
    be        = '0;
    lane_data = '0;
    align_err = 1'b0;
    case (sop)
      SOP_SW: begin
        lane_data = wdata;
        if (addr_lo != 2'b00) begin
          align_err = 1'b1;
        end else begin
          be = 4'b1111;
        end
      end
      SOP_SH: begin
        // Same halfword on both halves; be picks which one lands.
        lane_data = {2{wdata[15:0]}};
        if (addr_lo[0]) begin
          align_err = 1'b1;
        end else begin
          be = addr_lo[1] ? 4'b1100 : 4'b0011;
        end
      end
      SOP_SB: begin
        lane_data = {4{wdata[7:0]}};
        be        = 4'b0001 << addr_lo;
      end
      default: begin
        // SOP_RSV and unknown encodings.
        align_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dm_store.sv
// Word-organised data memory with a store-side narrowing unit.
// Read data is the raw word at addr[ADDR_WIDTH+1:2]; load extension lives outside.
// Ports:
//   clk, reset  - rising-edge clock, asynchronous active-high reset
//   we          - store request this cycle
//   SOp         - store width: 00 sw, 01 sh, 10 sb, 11 reserved
//   addr        - byte address from the ALU (high bits ignored, wraps mod memory size)
//   wdata       - store data (GPR[rt])
//   rdata       - combinational read of the addressed word (pre-write during a commit)
//   be          - byte enables of the current request, 0000 when idle or erroneous
//   align_err   - current request misaligned/reserved, 0 when idle
//   err_sticky  - set by any erroneous request, cleared only by reset
//   store_cnt   - count of committed stores, wraps
module dm_store
  import mips_defs::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter bit          RESET_CLEAR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  SOp,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [3:0]  be,
  output logic        align_err,
  output logic        err_sticky,
  output logic [31:0] store_cnt
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [31:0]           mem [Depth];
  logic [ADDR_WIDTH-1:0] widx;
  logic [3:0]            pack_be;
  logic [31:0]           lane_data;
  logic                  pack_err;
  logic                  x_err;
  logic                  commit;
  logic [31:0]           merged;
  logic                  unused_addr;

  assign widx        = addr[ADDR_WIDTH+1:2];
  assign unused_addr = ^addr[31:ADDR_WIDTH+2];
  assign rdata       = mem[widx];

  store_lane_pack u_pack (
    .sop      (SOp),
    .addr_lo  (addr[1:0]),
    .wdata    (wdata),
    .be       (pack_be),
    .lane_data(lane_data),
    .align_err(pack_err)
  );

  // An unknown width or address must never reach the array: treat it as an error.
  always_comb begin
    x_err = 1'b0;
`ifndef SYNTHESIS
    x_err = $isunknown({SOp, addr[ADDR_WIDTH+1:0]});
`endif
  end

  always_comb begin
    align_err = we & (pack_err | x_err);
    commit    = we & ~align_err;
    be        = commit ? pack_be : 4'b0000;
  end

  // Enabled lanes take new data, the rest keep the current word.
  always_comb begin
    merged = rdata;
    for (int i = 0; i < int'(WORD_BYTES); i++) begin
      if (be[i]) begin
        merged[i*LANE_W +: LANE_W] = lane_data[i*LANE_W +: LANE_W];
      end
    end
  end

  if (RESET_CLEAR) begin : g_mem_clear
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < int'(Depth); i++) begin
          mem[i] <= '0;
        end
      end else if (commit) begin
        mem[widx] <= merged;
      end
    end
  end else begin : g_mem_keep
    // Contents survive reset, but a store seen while reset is high is still dropped.
    always_ff @(posedge clk) begin
      if (commit && !reset) begin
        mem[widx] <= merged;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      store_cnt  <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (commit) begin
        store_cnt <= store_cnt + 32'd1;
      end
      if (align_err) begin
        err_sticky <= 1'b1;
      end
    end
  end

`ifdef DM_STORE_DEBUG
  always_ff @(posedge clk) begin
    if (commit && !reset) begin
      $display("%0t dm_store: [%08h] <= %08h", $time, {addr[31:2], 2'b00}, merged);
    end
  end
`endif

endmodule

// File: tb/tb_dm_store.sv
module tb_dm_store;

  logic        clk;
  logic        reset;
  logic        we;
  logic [1:0]  SOp;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  be;
  logic        align_err;
  logic        err_sticky;
  logic [31:0] store_cnt;

  int n_checks;
  int n_errors;

  dm_store #(
    .ADDR_WIDTH (10),
    .RESET_CLEAR(1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .SOp       (SOp),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .be        (be),
    .align_err (align_err),
    .err_sticky(err_sticky),
    .store_cnt (store_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational read with no store pending.
  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    we   = 1'b0;
    addr = a;
    #1;
    d = rdata;
  endtask

  // Present a store at the falling edge so comb outputs can be checked before the commit.
  task automatic present(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we    = 1'b1;
    SOp   = op;
    addr  = a;
    wdata = d;
    #1;
  endtask

  task automatic finish_store;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b1;
    we    = 1'b0;
    SOp   = 2'b00;
    addr  = '0;
    wdata = '0;
    #1;
    n_checks++;
    if (store_cnt !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_cnt: got %h want %h", store_cnt, 32'd0);
    end
    n_checks++;
    if (err_sticky !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_err: got %b want 0", err_sticky);
    end
    rd(32'h0000_0010, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_mem: got %h want 0", d);
    end
    n_checks++;
    if (be !== 4'b0000 || align_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle: be=%b err=%b want 0000/0", be, align_err);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_sb_merge;
    logic [31:0] d;
    present(2'b00, 32'h10, 32'hDEAD_BEEF);
    n_checks++;
    if (be !== 4'b1111 || align_err !== 1'b0) begin
      n_errors++;
      $display("FAIL sw_be: be=%b err=%b want 1111/0", be, align_err);
    end
    finish_store();
    present(2'b10, 32'h12, 32'h0000_00AA);
    n_checks++;
    if (be !== 4'b0100) begin
      n_errors++;
      $display("FAIL sb_be: got %b want 0100", be);
    end
    finish_store();
    rd(32'h10, d);
    n_checks++;
    if (d !== 32'hDEAA_BEEF) begin
      n_errors++;
      $display("FAIL sb_merge: got %h want DEAABEEF", d);
    end
    n_checks++;
    if (store_cnt !== 32'd2) begin
      n_errors++;
      $display("FAIL sb_cnt: got %0d want 2", store_cnt);
    end
  endtask

  task automatic test_sh_upper;
    logic [31:0] d;
    present(2'b00, 32'h20, 32'h1122_3344);
    finish_store();
    present(2'b01, 32'h22, 32'h1234_ABCD);
    n_checks++;
    if (be !== 4'b1100) begin
      n_errors++;
      $display("FAIL sh_be: got %b want 1100", be);
    end
    finish_store();
    rd(32'h20, d);
    n_checks++;
    if (d !== 32'hABCD_3344) begin
      n_errors++;
      $display("FAIL sh_merge: got %h want ABCD3344", d);
    end
    // Lower halfword, high wdata bits must not leak.
    present(2'b01, 32'h20, 32'hFFFF_5566);
    n_checks++;
    if (be !== 4'b0011) begin
      n_errors++;
      $display("FAIL sh_lo_be: got %b want 0011", be);
    end
    finish_store();
    rd(32'h20, d);
    n_checks++;
    if (d !== 32'hABCD_5566) begin
      n_errors++;
      $display("FAIL sh_lo_merge: got %h want ABCD5566", d);
    end
  endtask

  task automatic test_misaligned;
    logic [31:0] d;
    logic [1:0]  ops [3];
    logic [31:0] adrs [3];
    ops[0] = 2'b00; adrs[0] = 32'h05;
    ops[1] = 2'b01; adrs[1] = 32'h07;
    ops[2] = 2'b11; adrs[2] = 32'h10;
    // err_sticky must still be clear here: every prior request was legal.
    n_checks++;
    if (err_sticky !== 1'b0) begin
      n_errors++;
      $display("FAIL sticky_pre: got %b want 0", err_sticky);
    end
    for (int i = 0; i < 3; i++) begin
      present(ops[i], adrs[i], 32'hFFFF_FFFF);
      n_checks++;
      if (be !== 4'b0000 || align_err !== 1'b1) begin
        n_errors++;
        $display("FAIL bad_req%0d: be=%b err=%b want 0000/1", i, be, align_err);
      end
      finish_store();
      n_checks++;
      if (err_sticky !== 1'b1) begin
        n_errors++;
        $display("FAIL bad_sticky%0d: got %b want 1", i, err_sticky);
      end
    end
    n_checks++;
    if (store_cnt !== 32'd5) begin
      n_errors++;
      $display("FAIL bad_cnt: got %0d want 5", store_cnt);
    end
    rd(32'h04, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_errors++;
      $display("FAIL bad_mem04: got %h want 0", d);
    end
    rd(32'h10, d);
    n_checks++;
    if (d !== 32'hDEAA_BEEF) begin
      n_errors++;
      $display("FAIL bad_mem10: got %h want DEAABEEF", d);
    end
    // Idle with reserved SOp: no error reported.
    SOp = 2'b11;
    addr = 32'h05;
    #1;
    n_checks++;
    if (be !== 4'b0000 || align_err !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_rsv: be=%b err=%b want 0000/0", be, align_err);
    end
  endtask

  task automatic test_wrap_rbw;
    logic [31:0] d;
    present(2'b00, 32'h1004, 32'h5A5A_5A5A);
    n_checks++;
    if (rdata !== 32'h0) begin
      n_errors++;
      $display("FAIL rbw_old: got %h want 0", rdata);
    end
    finish_store();
    rd(32'h0004, d);
    n_checks++;
    if (d !== 32'h5A5A_5A5A) begin
      n_errors++;
      $display("FAIL wrap: got %h want 5A5A5A5A", d);
    end
    present(2'b10, 32'h33, 32'hFFFF_FF77);
    n_checks++;
    if (be !== 4'b1000) begin
      n_errors++;
      $display("FAIL sb3_be: got %b want 1000", be);
    end
    finish_store();
    rd(32'h30, d);
    n_checks++;
    if (d !== 32'h7700_0000) begin
      n_errors++;
      $display("FAIL sb3_merge: got %h want 77000000", d);
    end
    n_checks++;
    if (store_cnt !== 32'd7) begin
      n_errors++;
      $display("FAIL wrap_cnt: got %0d want 7", store_cnt);
    end
  endtask

  task automatic test_reset_clear;
    logic [31:0] d;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (store_cnt !== 32'd0 || err_sticky !== 1'b0) begin
      n_errors++;
      $display("FAIL async_regs: cnt=%h err=%b want 0/0", store_cnt, err_sticky);
    end
    rd(32'h10, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_errors++;
      $display("FAIL clr10: got %h want 0", d);
    end
    rd(32'h20, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_errors++;
      $display("FAIL clr20: got %h want 0", d);
    end
    rd(32'h04, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_errors++;
      $display("FAIL clr04: got %h want 0", d);
    end
  endtask

  // Entered with reset still high.
  task automatic test_reset_discard;
    logic [31:0] d;
    we    = 1'b1;
    SOp   = 2'b00;
    addr  = 32'h40;
    wdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    we    = 1'b0;
    #1;
    n_checks++;
    if (store_cnt !== 32'd0) begin
      n_errors++;
      $display("FAIL discard_cnt: got %0d want 0", store_cnt);
    end
    rd(32'h40, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_errors++;
      $display("FAIL discard_mem: got %h want 0", d);
    end
    present(2'b00, 32'h40, 32'hCAFE_F00D);
    finish_store();
    rd(32'h40, d);
    n_checks++;
    if (d !== 32'hCAFE_F00D) begin
      n_errors++;
      $display("FAIL post_rst_mem: got %h want CAFEF00D", d);
    end
    n_checks++;
    if (store_cnt !== 32'd1) begin
      n_errors++;
      $display("FAIL post_rst_cnt: got %0d want 1", store_cnt);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_sb_merge();
    test_sh_upper();
    test_misaligned();
    test_wrap_rbw();
    test_reset_clear();
    test_reset_discard();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dm_store.md
Name: dm_store

Overview:
- Data memory with a store-side narrowing unit for the single-cycle/multi-cycle MIPS datapath.
- It is the inverse of the immediate/load extension path. It takes a 32-bit register value and narrows it to word, halfword or byte, driving per-lane byte enables into a word-organised RAM.
- Read data is the raw 32-bit word; load-side extension happens outside this block.
- Sits between the ALU address output, the GPR rt read port and the write-back mux.

Parameters:
- ADDR_WIDTH, 10, number of word-address bits (1024 words = 4 KB).
- RESET_CLEAR, 1, when 1 the asynchronous reset zeroes every memory word; when 0 contents are untouched by reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- we  input  1  store request for this cycle.
- SOp  input  2  store width: 00 sw, 01 sh, 10 sb, 11 reserved.
- addr  input  32  byte address from the ALU.
- wdata  input  32  store data (GPR[rt]).
- rdata  output  32  word at addr[ADDR_WIDTH+1:2], combinational.
- be  output  4  byte enables of the current request, combinational, 0000 when we=0.
- align_err  output  1  current request is misaligned or reserved, combinational, 0 when we=0.
- err_sticky  output  1  registered; set on any erroneous request, cleared only by reset.
- store_cnt  output  32  registered count of committed stores.

Behaviour:
- Reset (async, dominant):
  - err_sticky=0 and store_cnt=0 immediately.
  - If RESET_CLEAR=1, all words read 0 immediately.
  - A store sampled in the same edge as reset, or while reset is high, is discarded.
- Word index: widx = addr[ADDR_WIDTH+1:2]. Higher address bits are ignored, so accesses wrap modulo 4 KB. addr[1:0] selects the lane.
- Lane mapping is little-endian: lane 0 = bits 7:0.
- sw (00):
  - be=1111, word written with wdata.
  - addr[1:0]!=00 is an error.
- sh (01):
  - addr[1]=0: be=0011, bits 15:0 get wdata[15:0].
  - addr[1]=1: be=1100, bits 31:16 get wdata[15:0].
  - addr[0]=1 is an error.
- sb (10):
  - be=0001<<addr[1:0]; the selected lane gets wdata[7:0].
  - Never misaligned.
- SOp=11: always an error; be=0000.
- Error request:
  - be forced to 0000, no memory change, store_cnt unchanged.
  - err_sticky is set at the next rising edge.
- Commit:
  - On a rising edge with we=1, align_err=0 and reset=0, the enabled lanes are written. Lanes not enabled keep their prior value.
  - store_cnt increments by 1 and wraps 0xFFFFFFFF -> 0.
- Latency:
  - A write is visible on rdata after the committing edge.
  - During the committing cycle, rdata shows the pre-write word (read-before-write on the same index).
- Ignored inputs: wdata bits above the narrowed width are ignored for sh/sb.
- X-safety: we=1 with SOp or addr unknown must not corrupt other words. In simulation, treat this as an error.
- Optional debug: each committed store emits a $display of time, byte address (word-aligned), merged word. This is an ifdef'd debug print only.
- No state machine beyond the array and the two registers. Every commit is a single cycle; there is no back-pressure.

Decomposition:
- Shared package (mips_defs): SOp encodings SOP_SW=2'b00, SOP_SH=2'b01, SOP_SB=2'b10, SOP_RSV=2'b11; LANE_W=8; WORD_BYTES=4.
- One sub-module, store_lane_pack. It is purely combinational: (SOp, addr[1:0], wdata) -> (be, packed 32-bit lane data, align_err).
- The top holds the RAM array, the merge by be, and the counters.

Test Plan:
- Reset with RESET_CLEAR=1 after prior writes -> rdata=0 at every probed index; store_cnt=0; err_sticky=0; all asynchronous, without a clock edge.
- sw addr=0x10, wdata=0xDEADBEEF, then sb addr=0x12, wdata=0x000000AA -> rdata@0x10 = 0xDEAABEEF; be=0100 during the sb; store_cnt=2.
- sh addr=0x22, wdata=0x1234ABCD over a word holding 0x11223344 -> word becomes 0xABCD3344; be=1100; wdata[31:16] ignored.
- Misaligned sw addr=0x05 and sh addr=0x07 -> be=0000, align_err=1, memory unchanged, err_sticky=1 after the edge, store_cnt unchanged. SOp=11 behaves the same.
- Wrap: sw addr=0x1004, wdata=0x5A5A5A5A -> rdata for addr=0x0004 = 0x5A5A5A5A. Read-before-write: during the committing cycle rdata shows the old value.
- Reset asserted mid-cycle with we=1, sw pending -> store discarded; store_cnt=0 after release. The first store after release commits normally.
